sram_ctrl: RTL and testbench

Bus-side initiator for the 256K×16 asynchronous SRAM on the DE2 board (the IS61LV25616 part used as SoC data memory). Accepts 32-bit word requests from the SoC data bus and turns each into up to two 16-bit SRAM accesses, low halfword then high halfword. Byte-masked writes are supported. The block sits between the data-bus interconnect and the board SRAM pins. The tristate on the data pins is resolved in the pad wrapper, not in this block.

---
 rtl/sram_ctrl_pkg.sv | 53 +++++
 rtl/sram_ctrl.sv | 116 +++++++++++
 tb/tb_sram_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and helpers for the DE2 SRAM initiator
package sram_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int ACCESS_CYCLES_DEF = 2;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  typedef struct packed {
    logic               ce_n;
    logic               we_n;
    logic               oe_n;
    logic               ub_n;
    logic               lb_n;
    logic               dq_oe;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] dq;
  } pins_t;

  localparam pins_t PINS_RESET = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, ub_n: 1'b1,
                                   lb_n: 1'b1, dq_oe: 1'b0, addr: '0, dq: '0};

  // Pin image for the first cycle of a halfword phase.
  function automatic pins_t phase_pins(input logic hi, input logic wr,
                                       input logic [16:0] word, input logic [31:0] wdata,
                                       input logic [3:0] mask);
    pins_t p;
    p.ce_n  = 1'b0;
    p.we_n  = ~wr;
    p.oe_n  = wr;
    p.dq_oe = wr;
    p.addr  = {word, hi};
    p.dq    = wr ? (hi ? wdata[31:16] : wdata[15:0]) : '0;
    p.lb_n  = wr & ~(hi ? mask[2] : mask[0]);
    p.ub_n  = wr & ~(hi ? mask[3] : mask[1]);
    return p;
  endfunction

  // Strobes released; address and data keep their last value.
  function automatic pins_t release_pins(input pins_t p);
    pins_t r;
    r       = p;
    r.ce_n  = 1'b1;
    r.we_n  = 1'b1;
    r.oe_n  = 1'b1;
    r.ub_n  = 1'b1;
    r.lb_n  = 1'b1;
    r.dq_oe = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit bus to 16-bit async SRAM initiator, two halfword phases
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic               io_clk,
  input  logic               io_reset,
  input  logic               io_sib_sel,
  input  logic               io_sib_write,
  input  logic [31:0]        io_sib_addr,
  input  logic [31:0]        io_sib_wdata,
  input  logic [3:0]         io_sib_mask,
  output logic [31:0]        io_sib_rdata,
  output logic               io_sib_ready,
  output logic               io_sib_resp,
  output logic [SRAM_AW-1:0] io_sram_addr,
  output logic [SRAM_DW-1:0] io_sram_dq_o,
  output logic               io_sram_dq_oe,
  input  logic [SRAM_DW-1:0] io_sram_dq_i,
  output logic               io_sram_ce_n,
  output logic               io_sram_we_n,
  output logic               io_sram_oe_n,
  output logic               io_sram_ub_n,
  output logic               io_sram_lb_n
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  pins_t       pins_q;
  logic        write_q;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic [31:0] rdata_q;
  logic        ready_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{io_sib_addr[31:19], io_sib_addr[1:0]};

  always_ff @(posedge io_clk or negedge io_reset) begin
    if (!io_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pins_q  <= PINS_RESET;
      write_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io_sib_sel) begin
            write_q <= io_sib_write;
            word_q  <= io_sib_addr[18:2];
            wdata_q <= io_sib_wdata;
            mask_q  <= io_sib_mask;
            cnt_q   <= CNT_LOAD;
            // Only writes may skip a halfword; reads always fetch both.
            if (!io_sib_write || (io_sib_mask[1:0] != 2'b00)) begin
              state_q <= LO;
              pins_q  <= phase_pins(1'b0, io_sib_write, io_sib_addr[18:2], io_sib_wdata, io_sib_mask);
            end else if (io_sib_mask[3:2] != 2'b00) begin
              state_q <= HI;
              pins_q  <= phase_pins(1'b1, io_sib_write, io_sib_addr[18:2], io_sib_wdata, io_sib_mask);
            end else begin
              state_q <= DONE;
              ready_q <= 1'b1;
            end
          end
        end
        LO, HI: begin
          if (cnt_q == 4'd0) begin
            if (!write_q) begin
              if (state_q == LO) rdata_q[15:0]  <= io_sram_dq_i;
              else               rdata_q[31:16] <= io_sram_dq_i;
            end
            if ((state_q == LO) && (!write_q || (mask_q[3:2] != 2'b00))) begin
              state_q <= HI;
              cnt_q   <= CNT_LOAD;
              pins_q  <= phase_pins(1'b1, write_q, word_q, wdata_q, mask_q);
            end else begin
              state_q <= DONE;
              ready_q <= 1'b1;
              pins_q  <= release_pins(pins_q);
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
            // Raise we_n one cycle early so address and data are held past the write edge.
            if (cnt_q == 4'd1) pins_q.we_n <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_sib_rdata  = rdata_q;
  assign io_sib_ready  = ready_q;
  assign io_sib_resp   = 1'b1;
  assign io_sram_addr  = pins_q.addr;
  assign io_sram_dq_o  = pins_q.dq;
  assign io_sram_dq_oe = pins_q.dq_oe;
  assign io_sram_ce_n  = pins_q.ce_n;
  assign io_sram_we_n  = pins_q.we_n;
  assign io_sram_oe_n  = pins_q.oe_n;
  assign io_sram_ub_n  = pins_q.ub_n;
  assign io_sram_lb_n  = pins_q.lb_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - scoreboard bench for sram_ctrl with N=2 and N=4 instances
module tb_sram_ctrl;

  typedef struct {
    string       tag;
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        sel    [2];
  logic        wr_a   [2];
  logic [31:0] addr_a [2];
  logic [31:0] wdata_a[2];
  logic [3:0]  mask_a [2];
  logic [31:0] rdata  [2];
  logic        ready  [2];
  logic        resp   [2];
  logic [17:0] addr_o [2];
  logic [15:0] dq_o   [2];
  logic        dq_oe  [2];
  logic [15:0] dq_i   [2];
  logic        ce_n   [2];
  logic        we_n   [2];
  logic        oe_n   [2];
  logic        ub_n   [2];
  logic        lb_n   [2];

  logic [15:0] mem [2][262144];
  exp_t        sbq [2][$];
  logic [17:0] addr_log [2][$];
  int          ce_cnt [2];
  int          we_cnt [2];
  int          viol   [2];
  logic [1:0]  lbub   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_ctrl #(.ACCESS_CYCLES(g == 0 ? 2 : 4)) u_dut (
      .io_clk       (clk),
      .io_reset     (rst_n),
      .io_sib_sel   (sel[g]),
      .io_sib_write (wr_a[g]),
      .io_sib_addr  (addr_a[g]),
      .io_sib_wdata (wdata_a[g]),
      .io_sib_mask  (mask_a[g]),
      .io_sib_rdata (rdata[g]),
      .io_sib_ready (ready[g]),
      .io_sib_resp  (resp[g]),
      .io_sram_addr (addr_o[g]),
      .io_sram_dq_o (dq_o[g]),
      .io_sram_dq_oe(dq_oe[g]),
      .io_sram_dq_i (dq_i[g]),
      .io_sram_ce_n (ce_n[g]),
      .io_sram_we_n (we_n[g]),
      .io_sram_oe_n (oe_n[g]),
      .io_sram_ub_n (ub_n[g]),
      .io_sram_lb_n (lb_n[g])
    );
    assign dq_i[g] = (!ce_n[g] && !oe_n[g]) ? mem[g][addr_o[g]] : 16'h0000;
  end

  // SRAM model: bytes are written in every cycle that ce_n and we_n are both low.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!ce_n[i] && !we_n[i]) begin
        if (!lb_n[i]) mem[i][addr_o[i]][7:0]  = dq_o[i][7:0];
        if (!ub_n[i]) mem[i][addr_o[i]][15:8] = dq_o[i][15:8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (!oe_n[i] && dq_oe[i]) viol[i]++;
        if (!ce_n[i]) begin
          ce_cnt[i]++;
          addr_log[i].push_back(addr_o[i]);
          lbub[i] = {lb_n[i], ub_n[i]};
          if (!we_n[i]) we_cnt[i]++;
        end
        if (ready[i]) begin
          if (sbq[i].size() == 0) chk("unexpected_ready", 1, 0);
          else begin
            e = sbq[i].pop_front();
            chk({e.tag, "_lat"}, 64'(cyc), 64'(e.cyc));
            if (e.rd) chk({e.tag, "_rdata"}, rdata[i], e.data);
          end
        end
      end
    end
  end

  task automatic wait_left(input int i, input int left);
    int n = 0;
    while (sbq[i].size() > left && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sbq[i].size() > left) begin
      chk("ready_timeout", 1, 0);
      sbq[i].delete();
    end
    #1;
  endtask

  task automatic do_req(input int i, input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m, input int lat,
                        input logic [31:0] rd);
    exp_t e;
    @(posedge clk);
    #1;
    ce_cnt[i] = 0;
    we_cnt[i] = 0;
    addr_log[i].delete();
    wr_a[i] = wr; addr_a[i] = a; wdata_a[i] = wd; mask_a[i] = m; sel[i] = 1'b1;
    e.tag = tag; e.cyc = cyc + lat; e.rd = !wr; e.data = rd;
    sbq[i].push_back(e);
    wait_left(i, 0);
    sel[i] = 1'b0;
  endtask

  task automatic chk_idle_pins(input string tag, input int i);
    chk({tag, "_strobes"}, {ce_n[i], we_n[i], oe_n[i], ub_n[i], lb_n[i], dq_oe[i], ready[i], resp[i]},
        8'b1111_1001);
    chk({tag, "_buses"}, {addr_o[i], dq_o[i], rdata[i]}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 0; wr_a[i] = 0; addr_a[i] = 0; wdata_a[i] = 0; mask_a[i] = 0;
      ce_cnt[i] = 0; we_cnt[i] = 0; viol[i] = 0; lbub[i] = 2'b11;
    end
    #2 rst_n = 1'b0;
    #1;
    chk_idle_pins("reset0", 0);
    chk_idle_pins("reset1", 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_req(0, "wr_full", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 5, 0);
    chk("wr_full_we_cycles", 64'(we_cnt[0]), 2);
    chk("wr_full_ce_cycles", 64'(ce_cnt[0]), 4);
    chk("wr_full_mem_lo", mem[0][18'h80], 16'hBEEF);
    chk("wr_full_mem_hi", mem[0][18'h81], 16'hDEAD);
    do_req(0, "rd_full", 1'b0, 32'h0000_0100, 0, 4'h0, 5, 32'hDEAD_BEEF);

    mem[0][18'h82] = 16'hFFFF;
    mem[0][18'h83] = 16'hFFFF;
    do_req(0, "wr_byte", 1'b1, 32'h0000_0104, 32'h1122_3344, 4'h4, 3, 0);
    chk("wr_byte_ce_cycles", 64'(ce_cnt[0]), 2);
    chk("wr_byte_addr", addr_log[0][0], 18'h83);
    chk("wr_byte_lb_ub", lbub[0], 2'b01);
    chk("wr_byte_mem", {mem[0][18'h83], mem[0][18'h82]}, 32'hFF22_FFFF);
    do_req(0, "rd_byte", 1'b0, 32'h0000_0104, 0, 4'h0, 5, 32'hFF22_FFFF);

    do_req(0, "wr_mask0", 1'b1, 32'h0000_0100, 32'h5555_5555, 4'h0, 1, 0);
    chk("wr_mask0_ce_cycles", 64'(ce_cnt[0]), 0);
    chk("wr_mask0_mem", {mem[0][18'h81], mem[0][18'h80]}, 32'hDEAD_BEEF);

    do_req(0, "rd_alias", 1'b0, 32'h0008_0100, 0, 4'h0, 5, 32'hDEAD_BEEF);
    chk("rd_alias_ce_cycles", 64'(addr_log[0].size()), 4);
    chk("rd_alias_addr_lo", addr_log[0][0], 18'h80);
    chk("rd_alias_addr_hi", addr_log[0][3], 18'h81);

    // Reset in the middle of the HI phase of a read.
    @(posedge clk);
    #1;
    wr_a[0] = 1'b0; addr_a[0] = 32'h0000_0100; sel[0] = 1'b1;
    n = 0;
    while (!(ce_n[0] == 1'b0 && addr_o[0] == 18'h81) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_hi", addr_o[0], 18'h81);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_pins("rst_mid", 0);
    sel[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(0, "rd_after_rst", 1'b0, 32'h0000_0104, 0, 4'h0, 5, 32'hFF22_FFFF);

    // Back-to-back reads on the ACCESS_CYCLES=4 instance with sel held.
    mem[1][18'h20] = 16'h5678; mem[1][18'h21] = 16'h1234;
    mem[1][18'h22] = 16'hBBBB; mem[1][18'h23] = 16'hAAAA;
    @(posedge clk);
    #1;
    wr_a[1] = 1'b0; addr_a[1] = 32'h0000_0040; sel[1] = 1'b1;
    e.tag = "b2b_first";  e.cyc = cyc + 9;  e.rd = 1'b1; e.data = 32'h1234_5678;
    sbq[1].push_back(e);
    e.tag = "b2b_second"; e.cyc = cyc + 19; e.rd = 1'b1; e.data = 32'hAAAA_BBBB;
    sbq[1].push_back(e);
    wait_left(1, 1);
    addr_a[1] = 32'h0000_0044;
    wait_left(1, 0);
    sel[1] = 1'b0;
    repeat (3) @(posedge clk);

    chk("no_contention_n2", 64'(viol[0]), 0);
    chk("no_contention_n4", 64'(viol[1]), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
